// File: rtl/rr_arbiter_pipe_pkg.sv
// rr_arbiter_pipe_pkg: system-wide defaults shared by the round-robin arbiter slice.
// The NUM_REQ default comes from the RR_ARB_NUM_REQ define, so a build can override it.
// Ports: none (package).
`ifndef RR_ARB_NUM_REQ
`define RR_ARB_NUM_REQ 4
`endif

package rr_arbiter_pipe_pkg;

  localparam int unsigned DEF_NUM_REQ    = `RR_ARB_NUM_REQ;
  localparam int unsigned DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/rr_arbiter_pipe_fixed_pri_enc.sv
// fixed_pri_enc: fixed-priority encoder; the lowest set request bit wins.
// Ports:
//   req   - request vector (WIDTH bits)
//   grant - one-hot grant, or all zero when req is zero
module fixed_pri_enc #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant
);

  // Two's-complement trick isolates the lowest set bit.
  assign grant = req & (~req + WIDTH'(1));

endmodule

// File: rtl/rr_arbiter_pipe.sv
// rr_arbiter_pipe: round-robin arbiter feeding a single registered output stage.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   in_valid  - per-requester valid (NUM_REQ bits)
//   in_data   - packed payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready  - one-hot (or zero) grant, combinational from in_valid/out_ready
//   out_valid - output register holds a granted item
//   out_ready - downstream accepts the held item
//   out_data  - registered payload of the granted requester
//   out_idx   - registered index of the granted requester
module rr_arbiter_pipe
  import rr_arbiter_pipe_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IDX_WIDTH-1:0]          out_idx
);

  logic [IDX_WIDTH-1:0]  ptr;
  logic [NUM_REQ-1:0]    above_ptr;
  logic [NUM_REQ-1:0]    masked;
  logic [NUM_REQ-1:0]    grant_masked;
  logic [NUM_REQ-1:0]    grant_all;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_WIDTH-1:0]  win_idx;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  load;
  logic                  handshake;

  // Output stage can take a new item when empty or draining this cycle.
  assign load = ~out_valid | out_ready;

  // Positions strictly above ptr; empty when ptr is the last index, so search wraps to 0.
  always_comb begin
    above_ptr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      above_ptr[i] = (32'(i) > 32'(ptr));
    end
  end

  assign masked = in_valid & above_ptr;

  fixed_pri_enc #(.WIDTH(NUM_REQ)) u_enc_masked (
    .req   (masked),
    .grant (grant_masked)
  );

  fixed_pri_enc #(.WIDTH(NUM_REQ)) u_enc_all (
    .req   (in_valid),
    .grant (grant_all)
  );

  assign grant = (|masked) ? grant_masked : grant_all;

  // Grant is only offered while out of reset and the output stage can load.
  assign in_ready  = (!rst && load) ? grant : '0;
  assign handshake = |in_ready;

  // One-hot grant to index and payload select.
  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_idx  = IDX_WIDTH'(i);
        win_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      ptr       <= IDX_WIDTH'(NUM_REQ - 1);
    end else if (handshake) begin
      out_valid <= 1'b1;
      out_data  <= win_data;
      out_idx   <= win_idx;
      ptr       <= win_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_pipe.sv
// tb_rr_arbiter_pipe: directed scenarios with literal expectations plus a random
// soak, all checked every cycle against a behavioural model and a scoreboard.
module tb_rr_arbiter_pipe;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_idx;

  int total = 0;
  int bad   = 0;

  rr_arbiter_pipe #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first valid index after ptr, wrapping, ending at ptr; -1 if none.
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Behavioural model state.
  bit            m_init = 0;
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_idx;
  int            m_ptr;

  always @(posedge clk) begin
    int w;
    if (rst) begin
      m_valid = 0;
      m_data  = '0;
      m_idx   = 0;
      m_ptr   = N - 1;
      m_init  = 1;
    end else if (m_init) begin
      w = rr_pick(in_valid, m_ptr);
      if ((!m_valid || out_ready) && w >= 0) begin
        m_valid = 1;
        m_data  = in_data[w*DW +: DW];
        m_idx   = w;
        m_ptr   = w;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  // Per-cycle compare, scoreboard and fairness tracking.
  logic [9:0] sb_q[$];
  int         waitc[N];

  always @(negedge clk) begin
    int w;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] hs;
    logic [9:0]   item;
    if (m_init) begin
      w = rr_pick(in_valid, m_ptr);
      exp_rdy = (!rst && (!m_valid || out_ready) && w >= 0) ? N'(1 << w) : '0;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("onehot", 32'($countones(in_ready) <= 1), 32'd1);
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        check("out_idx", 32'(out_idx), 32'(m_idx));
        check("out_data", 32'(out_data), 32'(m_data));
      end
      if (rst) begin
        sb_q.delete();
        for (int i = 0; i < N; i++) waitc[i] = 0;
      end else begin
        if (out_valid && out_ready) begin
          check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            item = sb_q.pop_front();
            check("sb_item", 32'({out_idx, out_data}), 32'(item));
          end
        end
        hs = in_valid & in_ready;
        for (int i = 0; i < N; i++) begin
          if (hs[i]) sb_q.push_back({2'(i), in_data[i*DW +: DW]});
        end
        for (int i = 0; i < N; i++) begin
          if (!in_valid[i] || hs[i]) begin
            waitc[i] = 0;
          end else if (hs != '0) begin
            waitc[i]++;
            check("fairness", 32'(waitc[i] <= N - 1), 32'd1);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] hs_drv;
  int           seq_a[5] = '{0, 1, 2, 3, 0};
  int           seq_b[3] = '{1, 3, 1};

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Reset state and in_ready forced low during reset.
    step();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    step();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_idx", 32'(out_idx), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);

    // All requesting: 0,1,2,3,0 at full throughput.
    rst = 1'b0;
    #1;
    check("first_grant", 32'(in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("seq_a_valid", 32'(out_valid), 32'h1);
      check("seq_a_idx", 32'(out_idx), 32'(seq_a[k]));
      check("seq_a_data", 32'(out_data), 32'(8'hA0 + seq_a[k]));
    end

    // Sparse valid 1010 from ptr=3: 1,3,1.
    rst      = 1'b1;
    in_valid = 4'b1010;
    step();
    rst = 1'b0;
    #1;
    check("sparse_first", 32'(in_ready), 32'h2);
    for (int k = 0; k < 3; k++) begin
      step();
      check("seq_b_idx", 32'(out_idx), 32'(seq_b[k]));
    end

    // Backpressure: held output, no grant, then grant coincident with drain.
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'h0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_in_ready", 32'(in_ready), 32'h0);
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_idx", 32'(out_idx), 32'h1);
      check("bp_data", 32'(out_data), 32'hA1);
    end
    out_ready = 1'b1;
    #1;
    check("drain_grant", 32'(in_ready), 32'h1);
    step();
    check("drain_idx", 32'(out_idx), 32'h0);
    check("drain_data", 32'(out_data), 32'hA0);

    // Wrap: requester 3 then requester 0.
    in_valid = 4'b1000;
    #1;
    check("wrap_g3", 32'(in_ready), 32'h8);
    step();
    check("wrap_idx3", 32'(out_idx), 32'h3);
    in_valid = 4'b0001;
    #1;
    check("wrap_g0", 32'(in_ready), 32'h1);
    step();
    check("wrap_idx0", 32'(out_idx), 32'h0);

    // Reset with an item held discards it; priority restarts at lowest index.
    in_valid  = '0;
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_idx", 32'(out_idx), 32'h0);
    rst       = 1'b0;
    in_valid  = 4'b0110;
    out_ready = 1'b1;
    #1;
    check("midrst_grant", 32'(in_ready), 32'h2);
    step();
    check("midrst_out", 32'(out_idx), 32'h1);

    // Random soak; valid held until granted.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      hs_drv = in_valid & in_ready;
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (hs_drv[i]) in_valid[i] = 1'b0;
        if (!in_valid[i] && $urandom_range(0, 1) == 1) begin
          in_valid[i] = 1'b1;
          in_data[i*DW +: DW] = 8'($urandom);
        end
      end
    end

    // Drain and confirm nothing was lost.
    in_valid  = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_pipe.md
RR_ARBITER_PIPE -- requirements
Module: rr_arbiter_pipe

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, 2..32.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload width per requester.
REQ-003 SHALL have parameter IDX_WIDTH, default $clog2(NUM_REQ): width of the granted-index field.
REQ-004 SHALL have clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have in_valid  input  NUM_REQ: per-requester valid.
REQ-007 SHALL have in_data  input  NUM_REQ*DATA_WIDTH: packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have in_ready  output  NUM_REQ: per-requester ready, one-hot or zero.
REQ-009 SHALL have out_valid  output  1: output register holds a granted item.
REQ-010 SHALL have out_ready  input  1: downstream accepts.
REQ-011 SHALL have out_data  output  DATA_WIDTH: registered payload.
REQ-012 SHALL have out_idx  output  IDX_WIDTH: registered index of the granted requester.

Function
REQ-013 SHALL compute load = ~out_valid | out_ready, combinationally.
REQ-014 SHALL select the winner round-robin: the first index with in_valid set, searching ptr+1, ptr+2, ... modulo NUM_REQ, ending at ptr.
REQ-015 SHALL implement the search as a two-pass mask: masked = in_valid & (bits above ptr); pick the lowest set bit of masked if nonzero, else the lowest set bit of in_valid.
REQ-016 SHALL drive in_ready as the one-hot winner when load=1 and |in_valid=1; otherwise all zero.
REQ-017 SHALL treat a handshake on requester i as in_valid[i] & in_ready[i]; at most one per cycle.
REQ-018 SHALL, on a handshake, register out_data=in_data[winner], out_idx=winner, out_valid=1, and set ptr=winner at the next edge (latency 1 cycle).
REQ-019 SHALL, when out_valid & out_ready and no new handshake, clear out_valid at the next edge; out_data and out_idx hold.
REQ-020 SHALL hold out_valid, out_data, and out_idx stable while out_valid=1 and out_ready=0.
REQ-021 SHALL update ptr only on a handshake, never on a request without a grant.
REQ-022 SHALL sustain one transfer per cycle when out_ready is held at 1 (simultaneous drain and load).
REQ-023 SHALL wrap ptr=NUM_REQ-1 so that the masked vector is empty and the search restarts at index 0.
REQ-024 SHALL allow in_ready to depend combinationally on in_valid and out_ready; no other input-to-output combinational path.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set out_valid=0, out_data=0, out_idx=0, ptr=NUM_REQ-1, so requester 0 has first priority after reset.
REQ-026 SHALL force in_ready=0 while rst=1.
REQ-027 SHALL discard an item held in the output register when reset is asserted mid-operation, with no further transfer.

Structure
REQ-028 SHALL place no typedefs in a shared package; NUM_REQ and DATA_WIDTH are overridable parameters, and a system-wide default for NUM_REQ comes from the shared define file.
REQ-029 SHALL instantiate one sub-module, fixed_pri_enc (parameter WIDTH, req in, one-hot grant out, lowest index wins), twice: once for masked and once for unmasked.
REQ-030 SHALL hold ptr as binary IDX_WIDTH bits and generate the mask combinationally from it.

Verification (NUM_REQ=4, DATA_WIDTH=8)
REQ-031 SHALL cover: after reset, in_valid=4'b1111, out_ready=1, data i=8'hA0+i -> out_idx sequence 0,1,2,3,0 on consecutive cycles, first out_valid one cycle after first grant.
REQ-032 SHALL cover: in_valid=4'b1010, ptr=3 -> grant 1, then 3, then 1; in_ready never shows 2 bits set.
REQ-033 SHALL cover: out_valid=1 with out_ready=0 for 5 cycles while in_valid=4'b0001 -> in_ready=0 and out_data stable, then out_ready=1 -> requester 0 is granted in the same cycle as the drain.
REQ-034 SHALL cover: a single requester 3 valid -> grant 3 and ptr=3, then requester 0 valid -> grant 0 (wrap).
REQ-035 SHALL cover: rst asserted with out_valid=1 -> next cycle out_valid=0 and out_idx=0, and the next grant goes to the lowest valid index.
REQ-036 SHALL cover: a random valid/ready soak of 10k cycles checked against a scoreboard -> no loss or duplication, and each requester waits at most NUM_REQ-1 grants to others.
